// File: rtl/dbg_trace_arbiter.sv
// dbg_trace_arbiter
// Captures fire-and-forget trace records from N_SRC sources into per-source
// holding registers. The registers are served round-robin, and each record
// leaves as a 7-flit debug NoC packet: HEADER, five PAYLOAD flits, then a LAST
// flit carrying the number of records dropped from that source since its
// previous packet.

module dbg_trace_arbiter #(
   parameter int N_SRC    = 4,
   parameter int DEST     = 0,
   parameter int SRC_BASE = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [N_SRC*80-1:0]  src_trace,
   input  logic [N_SRC-1:0]     src_valid,
   output logic [17:0]          out_flit,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 lost_any
);

   localparam int         IW      = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam logic [4:0] DEST_ID = DEST[4:0];
   localparam logic [7:0] BASE_ID = SRC_BASE[7:0];

   typedef enum logic {IDLE, SEND} state_t;

   state_t          state, state_nxt;
   logic [2:0]      idx, idx_nxt;
   logic [IW-1:0]   rr_ptr, rr_nxt;
   logic [IW-1:0]   gnt, gnt_nxt;
   logic [111:0]    pkt, pkt_nxt;
   logic [79:0]     hold [N_SRC];
   logic [15:0]     lost [N_SRC];
   logic [15:0]     lost_nxt [N_SRC];
   logic [N_SRC-1:0] full, full_nxt, load, grant_vec;
   logic            lost_any_nxt;
   logic            any_full;
   logic [IW-1:0]   pick;
   logic [IW:0]     cand;
   logic [1:0]      flit_type;

   // Find the first full holding register, searching from rr_ptr and wrapping
   always_comb begin
      any_full = 1'b0;
      pick     = '0;
      cand     = '0;
      for (int k = 0; k < N_SRC; k++) begin
         cand = {1'b0, rr_ptr} + (IW+1)'(k);
         if (cand >= (IW+1)'(N_SRC))
            cand = cand - (IW+1)'(N_SRC);
         if (!any_full && full[cand[IW-1:0]]) begin
            any_full = 1'b1;
            pick     = cand[IW-1:0];
         end
      end
   end

   // Packet FSM: grant in IDLE, then shift out seven flits on handshakes
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      rr_nxt    = rr_ptr;
      gnt_nxt   = gnt;
      pkt_nxt   = pkt;
      grant_vec = '0;
      out_valid = 1'b0;
      out_flit  = '0;
      flit_type = 2'b00;
      case (state)
         IDLE: begin
            if (any_full) begin
               grant_vec[pick] = 1'b1;
               gnt_nxt         = pick;
               pkt_nxt         = {DEST_ID, 3'b010, BASE_ID + 8'(pick), hold[pick], lost[pick]};
               idx_nxt         = 3'd0;
               state_nxt       = SEND;
            end
         end
         SEND: begin
            if (idx == 3'd0)
               flit_type = 2'b01;
            else if (idx == 3'd6)
               flit_type = 2'b10;
            out_valid = 1'b1;
            out_flit  = {flit_type, pkt[111:96]};
            if (out_ready) begin
               pkt_nxt = {pkt[95:0], 16'h0000};
               if (idx == 3'd6) begin
                  state_nxt = IDLE;
                  rr_nxt    = (gnt == IW'(N_SRC-1)) ? '0 : gnt + 1'b1;
               end else begin
                  idx_nxt = idx + 3'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Capture/drop decision per source; a register freed by a grant always captures
   always_comb begin
      full_nxt     = full;
      load         = '0;
      lost_any_nxt = lost_any;
      for (int i = 0; i < N_SRC; i++) begin
         lost_nxt[i] = lost[i];
         if (grant_vec[i]) begin
            full_nxt[i] = 1'b0;
            lost_nxt[i] = '0;
         end
         if (enable && src_valid[i]) begin
            if (!full[i] || grant_vec[i]) begin
               load[i]     = 1'b1;
               full_nxt[i] = 1'b1;
            end else begin
               if (lost[i] != 16'hFFFF)
                  lost_nxt[i] = lost[i] + 16'd1;
               lost_any_nxt = 1'b1;
            end
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Datapath registers: packet shifter, pointers, holding registers, counters, busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx      <= '0;
         rr_ptr   <= '0;
         gnt      <= '0;
         pkt      <= '0;
         full     <= '0;
         lost_any <= 1'b0;
         busy     <= 1'b0;
         for (int i = 0; i < N_SRC; i++) begin
            hold[i] <= '0;
            lost[i] <= '0;
         end
      end else begin
         idx      <= idx_nxt;
         rr_ptr   <= rr_nxt;
         gnt      <= gnt_nxt;
         pkt      <= pkt_nxt;
         full     <= full_nxt;
         lost_any <= lost_any_nxt;
         busy     <= (state_nxt == SEND) || (|full_nxt);
         for (int i = 0; i < N_SRC; i++) begin
            lost[i] <= lost_nxt[i];
            if (load[i])
               hold[i] <= src_trace[80*i +: 80];
         end
      end
   end

endmodule

// File: doc/dbg_trace_arbiter.md
# dbg_trace_arbiter

Round-robin arbiter and packetizer that shares one debug NoC output port between N software trace sources, typically the per-core STMs of a compute tile. Each source delivers fire-and-forget trace records that cannot be stalled. The block captures each record into a per-source holding register and counts records lost to overflow. It then serializes the records as 7-flit debug NoC packets addressed to the host debug interface. It sits between the STM trace outputs and the tile's debug NoC router/virtual-channel mux.

## Interface
Parameters:
- N_SRC, 4: number of trace sources (1..16).
- DEST, 0: 5-bit debug NoC destination of all packets.
- SRC_BASE, 0: 8-bit source ID of source 0; source i reports SRC_BASE+i.

Ports:
- clk  in  1  clock; every flop is in this domain.
- rst_n  in  1  reset, asynchronous, active low.
- enable  in  1  global capture enable; when 0, new records are ignored (not counted as lost); buffered records still drain.
- src_trace  in  N_SRC*80  record i at [80*i+79:80*i] = {timestamp[31:0], data[31:0], id[15:0]}.
- src_valid  in  N_SRC  one-cycle strobe per record; no backpressure toward sources.
- out_flit  out  18  {type[1:0], content[15:0]}; types: HEADER=01, PAYLOAD=00, LAST=10.
- out_valid  out  1  flit valid.
- out_ready  in  1  flit accepted when out_valid && out_ready.
- busy  out  1  1 while a packet is in flight or any holding register is full.
- lost_any  out  1  sticky; set on the first lost record; cleared only by reset.

## Operation
- Per source: holding register hold_i (80 b), flag full_i, 16-bit saturating counter lost_i.
- Capture: if enable && src_valid[i]:
  - If !full_i, or hold_i is granted this cycle, load hold_i and set full_i.
  - Otherwise drop the record: lost_i <= min(lost_i+1, 16'hFFFF) and set lost_any.
- FSM states: IDLE, SEND.
- IDLE: if any full_i, grant g = first full index searching rr_ptr, rr_ptr+1, …, wrapping mod N_SRC.
  - Copy hold_g and lost_g into the packet shift register.
  - Clear full_g unless re-captured the same cycle.
  - Clear lost_g. A drop on g cannot occur in the grant cycle, because a freed register always captures.
  - Move to SEND with flit index 0.
- SEND: drive flit[idx]; advance idx on each handshake. After the LAST flit is accepted: rr_ptr <= (g+1) mod N_SRC and go to IDLE.
- Packet, 7 flits:
  - Flit 0 HEADER content = {DEST[4:0], 3'b010, (SRC_BASE+g)[7:0]}.
  - Flits 1–5 PAYLOAD: ts[31:16], ts[15:0], data[31:16], data[15:0], id.
  - Flit 6 LAST: lost snapshot, i.e. records dropped from g since its previous packet.
- out_flit stays stable while out_valid && !out_ready.
- SRC_BASE+g is computed modulo 256.

## Timing
- Reset values: out_valid=0, out_flit=0, busy=0, lost_any=0, all full_i=0, lost_i=0, rr_ptr=0, FSM=IDLE. Reset takes effect immediately, including mid-packet; the partial packet is abandoned and no LAST flit is sent.
- Captured record is visible in full_i on the next cycle.
- Earliest HEADER: the cycle after the grant, i.e. 2 cycles after src_valid with an idle arbiter.
- With out_ready=1, a packet occupies 7 cycles plus 1 IDLE cycle, so sustained throughput is 1 packet per 8 cycles.
- out_valid never drops between flits once HEADER is presented; no bubbles are inserted mid-packet.
- busy is registered and reflects state after the current edge.

## Test plan
- Single record: src 2 strobes {ts=32'h00010002, data=32'hDEADBEEF, id=16'h0042}, N_SRC=4, DEST=3, SRC_BASE=8, out_ready=1 -> HEADER 16'h1A0A, then 0001, 0002, DEAD, BEEF, 0042, LAST 0000; out_valid rises 2 cycles after the strobe.
- Round-robin: all 4 sources strobe in the same cycle -> packets emitted in source order 0,1,2,3. Then sources 0 and 3 strobe again with rr_ptr=0 -> order 0,3.
- Overflow: out_ready=0, src 1 strobes 5 times -> one packet is held; later packets carry lost=3 (first record in flight, second buffered, three dropped). lost_any=1; the next src 1 packet after that carries lost=0.
- Backpressure: toggle out_ready randomly -> each flit appears exactly once with stable content while stalled; 7 flits per packet; HEADER/LAST framing correct.
- Capture on grant: src 0 strobes again in the exact cycle its register is granted -> new record is kept (not lost), and the packet for the new record follows.
- Reset mid-packet: assert rst_n=0 after flit 3 -> out_valid=0 asynchronously. After release, busy=0, no residual flits, and a fresh record produces a complete packet.
